// File: rtl/parking_gate_controller_pkg.sv
// rtl/parking_gate_controller_pkg.sv - gate FSM encodings and default lot parameters
package parking_gate_controller_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } gate_state_t;

  localparam int DEF_CAPACITY    = 200;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_GATE_CYCLES = 4;

endpackage

// File: rtl/parking_gate_controller_if.sv
// rtl/parking_gate_controller_if.sv - car sensor inputs and gate/status outputs
interface parking_gate_controller_if
  import parking_gate_controller_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             entry;
  logic             exit;
  logic             entry_grant;
  logic             entry_deny;
  logic             gate_open;
  logic [CNT_W-1:0] parked_count;
  logic [CNT_W-1:0] parking_capacity;
  logic             full;
  logic             empty;
  logic             exit_error;

  modport master (
    output entry, exit,
    input  entry_grant, entry_deny, gate_open, parked_count,
           parking_capacity, full, empty, exit_error
  );

  modport slave (
    input  entry, exit,
    output entry_grant, entry_deny, gate_open, parked_count,
           parking_capacity, full, empty, exit_error
  );
endinterface

// File: rtl/parking_gate_controller_gate_timer.sv
// rtl/parking_gate_controller_gate_timer.sv - OPEN dwell timer, done pulses on the last open cycle
module gate_timer
  import parking_gate_controller_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_done
);
  localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(GATE_CYCLES - 1);

  logic          r_run;
  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_run <= 1'b1;
      r_cnt <= LOAD_VAL;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = r_run && (r_cnt == '0);
endmodule

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - entry gate FSM with saturating occupancy counter
module parking_gate_controller
  import parking_gate_controller_pkg::*;
#(
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
  input logic                     clk,
  input logic                     reset,
  parking_gate_controller_if.slave bus
);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  gate_state_t      r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_free;
  logic             r_grant;
  logic             r_deny;
  logic             r_gate_open;
  logic             r_full;
  logic             r_empty;
  logic             r_exit_error;

  logic             w_idle;
  logic             w_accept;
  logic             w_refuse;
  logic             w_dec;
  logic             w_done;
  logic [CNT_W-1:0] w_count_nxt;

  // A concurrent exit frees the space the entering car takes, so full does not block it.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && bus.entry && (!r_full || bus.exit);
  assign w_refuse = w_idle && bus.entry && r_full && !bus.exit;
  assign w_dec    = bus.exit && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_accept && !bus.exit) begin
      if (r_count != CAP) w_count_nxt = r_count + 1'b1;
    end else if (!w_accept && w_dec) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  gate_timer #(.GATE_CYCLES(GATE_CYCLES)) u_gate_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept),
    .o_done (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_free       <= CAP;
      r_grant      <= 1'b0;
      r_deny       <= 1'b0;
      r_gate_open  <= 1'b0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_exit_error <= 1'b0;
    end else begin
      r_grant <= w_accept;
      r_deny  <= w_refuse;
      r_count <= w_count_nxt;
      r_free  <= CAP - w_count_nxt;
      r_full  <= (w_count_nxt == CAP);
      r_empty <= (w_count_nxt == '0);
      if (bus.exit && r_empty && !w_accept) r_exit_error <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_state     <= ST_OPEN;
          r_gate_open <= 1'b1;
        end
        ST_OPEN: if (w_done) begin
          r_state     <= ST_IDLE;
          r_gate_open <= 1'b0;
        end
      endcase
    end
  end

  assign bus.entry_grant      = r_grant;
  assign bus.entry_deny       = r_deny;
  assign bus.gate_open        = r_gate_open;
  assign bus.parked_count     = r_count;
  assign bus.parking_capacity = r_free;
  assign bus.full             = r_full;
  assign bus.empty            = r_empty;
  assign bus.exit_error       = r_exit_error;
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb/tb_parking_gate_controller.sv - table-driven and sequence checks on 200-space and 3-space lots
module tb_parking_gate_controller;
  import parking_gate_controller_pkg::*;

  typedef struct {
    logic r, en, ex;
    logic g, d, go;
    int   cnt;
    logic fu, em, er;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];

  parking_gate_controller_if #(.CNT_W(8)) if_a ();
  parking_gate_controller_if #(.CNT_W(8)) if_b ();

  parking_gate_controller #(.CAPACITY(200), .CNT_W(8), .GATE_CYCLES(4)) dut_a (
    .clk(clk), .reset(rst_a), .bus(if_a.slave)
  );
  parking_gate_controller #(.CAPACITY(3), .CNT_W(8), .GATE_CYCLES(4)) dut_b (
    .clk(clk), .reset(rst_b), .bus(if_b.slave)
  );

  function automatic logic [31:0] pack(logic g, logic d, logic go, int cnt, int cap,
                                       logic fu, logic em, logic er);
    logic [7:0] c8, f8;
    c8 = cnt[7:0];
    f8 = cap[7:0];
    return {10'd0, g, d, go, c8, f8, fu, em, er};
  endfunction

  function automatic logic [31:0] sample_a();
    return pack(if_a.entry_grant, if_a.entry_deny, if_a.gate_open, int'(if_a.parked_count),
                int'(if_a.parking_capacity), if_a.full, if_a.empty, if_a.exit_error);
  endfunction

  function automatic logic [31:0] sample_b();
    return pack(if_b.entry_grant, if_b.entry_deny, if_b.gate_open, int'(if_b.parked_count),
                int'(if_b.parking_capacity), if_b.full, if_b.empty, if_b.exit_error);
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got g/d/go/cnt/free/fu/em/er=%h required %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(int n, logic r, logic en, logic ex, logic g, logic d, logic go,
                     int cnt, logic fu, logic em, logic er);
    vec_t v;
    v.r = r; v.en = en; v.ex = ex; v.g = g; v.d = d; v.go = go;
    v.cnt = cnt; v.fu = fu; v.em = em; v.er = er;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    // 3-space lot: fill, deny, full swap, drain, underflow, reset mid-OPEN
    add(1, 1,0,0, 0,0,0, 0, 0,1,0);
    add(1, 0,1,0, 1,0,1, 1, 0,0,0);
    add(1, 0,1,0, 0,0,1, 1, 0,0,0);
    add(2, 0,0,0, 0,0,1, 1, 0,0,0);
    add(1, 0,0,0, 0,0,0, 1, 0,0,0);
    add(1, 0,1,0, 1,0,1, 2, 0,0,0);
    add(3, 0,0,0, 0,0,1, 2, 0,0,0);
    add(1, 0,0,0, 0,0,0, 2, 0,0,0);
    add(1, 0,1,0, 1,0,1, 3, 1,0,0);
    add(1, 0,0,1, 0,0,1, 2, 0,0,0);
    add(2, 0,0,0, 0,0,1, 2, 0,0,0);
    add(1, 0,0,0, 0,0,0, 2, 0,0,0);
    add(1, 0,1,0, 1,0,1, 3, 1,0,0);
    add(3, 0,0,0, 0,0,1, 3, 1,0,0);
    add(1, 0,0,0, 0,0,0, 3, 1,0,0);
    add(1, 0,1,0, 0,1,0, 3, 1,0,0);
    add(1, 0,1,1, 1,0,1, 3, 1,0,0);
    add(3, 0,0,0, 0,0,1, 3, 1,0,0);
    add(1, 0,0,0, 0,0,0, 3, 1,0,0);
    add(1, 0,0,1, 0,0,0, 2, 0,0,0);
    add(1, 0,0,1, 0,0,0, 1, 0,0,0);
    add(1, 0,0,1, 0,0,0, 0, 0,1,0);
    add(1, 0,0,1, 0,0,0, 0, 0,1,1);
    add(1, 0,0,0, 0,0,0, 0, 0,1,1);
    add(1, 0,1,1, 1,0,1, 0, 0,1,1);
    add(3, 0,0,0, 0,0,1, 0, 0,1,1);
    add(1, 0,0,0, 0,0,0, 0, 0,1,1);
    add(1, 1,0,0, 0,0,0, 0, 0,1,0);
    add(1, 0,1,0, 1,0,1, 1, 0,0,0);
    add(1, 0,0,0, 0,0,1, 1, 0,0,0);
    add(1, 1,1,0, 0,0,0, 0, 0,1,0);
    add(1, 0,1,0, 1,0,1, 1, 0,0,0);
    add(3, 0,0,0, 0,0,1, 1, 0,0,0);
    add(1, 0,0,0, 0,0,0, 1, 0,0,0);

    rst_a = 1'b1; rst_b = 1'b1;
    if_a.entry = 1'b0; if_a.exit = 1'b0;
    if_b.entry = 1'b0; if_b.exit = 1'b0;

    // 200-space lot: reset state and a single admission
    tick();
    check("a_reset", 0, sample_a(), pack(0,0,0, 0, 200, 0,1,0));
    rst_a = 1'b0; if_a.entry = 1'b1;
    tick();
    check("a_grant", 0, sample_a(), pack(1,0,1, 1, 199, 0,0,0));
    if_a.entry = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      check("a_open", k, sample_a(), pack(0,0,1, 1, 199, 0,0,0));
    end
    tick();
    check("a_closed", 0, sample_a(), pack(0,0,0, 1, 199, 0,0,0));

    // Entry held high: one grant every GATE_CYCLES+1 cycles
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0; if_a.entry = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      check("a_held", k, sample_a(),
            pack(k % 5 == 0, 0, k % 5 < 4, k / 5 + 1, 200 - (k / 5 + 1), 0,0,0));
    end
    if_a.entry = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rst_b = tbl[i].r; if_b.entry = tbl[i].en; if_b.exit = tbl[i].ex;
      tick();
      check("b_vec", i, sample_b(),
            pack(tbl[i].g, tbl[i].d, tbl[i].go, tbl[i].cnt, 3 - tbl[i].cnt,
                 tbl[i].fu, tbl[i].em, tbl[i].er));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
